err_feedback_unit: RTL and testbench

Closes the adaptation loop of the tap array. Consumes the per-tap products (`filter_out`) that each tap streams out one per cycle, accumulates them into the filter output y, forms e = d − y, scales by the step size mu, and drives the registered `mu_a_error_d` word that every tap's weight-update logic reads. Sits between the tap array output bus and the shared `mu_a_error_d` broadcast net.

---
 rtl/err_feedback_unit_pkg.sv | 22 ++
 rtl/err_feedback_unit_q_round_sat.sv | 25 ++
 rtl/err_feedback_unit.sv | 151 +++++++++++++++
 tb/tb_err_feedback_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/err_feedback_unit_pkg.sv
// Shared types and defaults for the error-feedback unit: FSM encoding and sizing helpers.
package err_feedback_unit_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_QP    = 12;
  localparam int unsigned DEF_NTAPS = 8;
  localparam int unsigned DEF_GUARD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_SUM   = 3'd2,
    S_ERR   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Counter must reach NTAPS+2 so an over-long sample is still distinguishable from NTAPS.
  function automatic int unsigned cnt_width(input int unsigned ntaps);
    return $clog2(ntaps + 2);
  endfunction

endpackage

// File: rtl/err_feedback_unit_q_round_sat.sv
// Combinational two's-complement saturator, WIDTH_IN -> WIDTH bits (same binary point).
module q_round_sat #(
  parameter int unsigned WIDTH_IN = 17,
  parameter int unsigned WIDTH    = 16
) (
  input  logic [WIDTH_IN-1:0] din_i,
  output logic [WIDTH-1:0]    dout_o
);

  localparam int unsigned HB = WIDTH_IN - WIDTH + 1;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [HB-1:0] hi;
  assign hi = din_i[WIDTH_IN-1 -: HB];

  // Value fits when all bits above the output sign bit agree with it.
  always_comb begin
    dout_o = din_i[WIDTH-1:0];
    if ((hi != {HB{1'b0}}) && (hi != {HB{1'b1}})) begin
      dout_o = din_i[WIDTH_IN-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/err_feedback_unit.sv
// Accumulates per-tap products into y, forms e = d - y, and broadcasts rounded mu*e to the taps.
module err_feedback_unit
  import err_feedback_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned QP    = DEF_QP,
  parameter int unsigned NTAPS = DEF_NTAPS,
  parameter int unsigned GUARD = DEF_GUARD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tap_in,
  input  logic             tap_valid,
  input  logic             tap_last,
  input  logic [WIDTH-1:0] desired,
  input  logic [WIDTH-1:0] mu,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] error_out,
  output logic [WIDTH-1:0] mu_a_error_d,
  output logic             err_valid,
  output logic             busy,
  output logic             count_err,
  output logic             overrun
);

  localparam int unsigned AW = WIDTH + GUARD;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(NTAPS);
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (QP - 1);

  state_e            state_q;
  logic [AW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  d_q;
  logic [WIDTH-1:0]  mu_q;
  logic [WIDTH-1:0]  y_q;
  logic [WIDTH-1:0]  error_q;
  logic [WIDTH-1:0]  mu_err_q;
  logic              err_valid_q;
  logic              busy_q;
  logic              count_err_q;
  logic              overrun_q;

  logic [AW-1:0]        tap_ext;
  logic [CW-1:0]        cnt_inc;
  logic [WIDTH-1:0]     y_sat;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     e_sat;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_rnd;
  logic                 unused_prod_bits;

  assign tap_ext = {{GUARD{tap_in[WIDTH-1]}}, tap_in};
  assign cnt_inc = cnt_q + CW'(1);
  assign diff    = {d_q[WIDTH-1], d_q} - {y_q[WIDTH-1], y_q};

  q_round_sat #(.WIDTH_IN(AW), .WIDTH(WIDTH)) u_sat_y (
    .din_i  (acc_q),
    .dout_o (y_sat)
  );

  q_round_sat #(.WIDTH_IN(WIDTH + 1), .WIDTH(WIDTH)) u_sat_e (
    .din_i  (diff),
    .dout_o (e_sat)
  );

  // Rounding kept bit-identical to the tap product path: add half LSB, truncate, no saturation.
  assign prod     = $signed(error_q) * $signed(mu_q);
  assign prod_rnd = prod + RND;
  assign unused_prod_bits = ^{prod_rnd[PW-1:QP+WIDTH], prod_rnd[QP-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      d_q         <= '0;
      mu_q        <= '0;
      y_q         <= '0;
      error_q     <= '0;
      mu_err_q    <= '0;
      err_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      count_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tap_valid) begin
            acc_q <= tap_ext;
            cnt_q <= CW'(1);
            if (tap_last) begin
              d_q     <= desired;
              mu_q    <= mu;
              busy_q  <= 1'b1;
              state_q <= S_SUM;
              if (CW'(1) != CW'(NTAPS)) count_err_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (tap_valid) begin
            acc_q <= acc_q + tap_ext;
            if (cnt_q <= CW'(NTAPS)) cnt_q <= cnt_inc;
            if (tap_last) begin
              d_q     <= desired;
              mu_q    <= mu;
              busy_q  <= 1'b1;
              state_q <= S_SUM;
              if (cnt_inc != CW'(NTAPS)) count_err_q <= 1'b1;
            end else if (cnt_inc > CW'(NTAPS)) begin
              count_err_q <= 1'b1;
            end
          end
        end
        S_SUM: begin
          y_q     <= y_sat;
          state_q <= S_ERR;
        end
        S_ERR: begin
          error_q <= e_sat;
          state_q <= S_DONE;
        end
        S_DONE: begin
          mu_err_q    <= prod_rnd[QP +: WIDTH];
          err_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
      // Products arriving while the sample is being finalised are dropped.
      if (busy_q && tap_valid) overrun_q <= 1'b1;
    end
  end

  assign y_out        = y_q;
  assign error_out    = error_q;
  assign mu_a_error_d = mu_err_q;
  assign err_valid    = err_valid_q;
  assign busy         = busy_q;
  assign count_err    = count_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_err_feedback_unit.sv
// Directed plus randomized bench for err_feedback_unit against an integer reference model.
module tb_err_feedback_unit;

  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tap_in;
  logic        tap_valid;
  logic        tap_last;
  logic [15:0] desired;
  logic [15:0] mu;
  logic [15:0] y_out;
  logic [15:0] error_out;
  logic [15:0] mu_a_error_d;
  logic        err_valid;
  logic        busy;
  logic        count_err;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] pb [0:15];
  logic [15:0] exp_y, exp_e, exp_m;
  logic        ce_exp, ov_exp;

  err_feedback_unit #(.WIDTH(16), .QP(12), .NTAPS(NT), .GUARD(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .tap_in       (tap_in),
    .tap_valid    (tap_valid),
    .tap_last     (tap_last),
    .desired      (desired),
    .mu           (mu),
    .y_out        (y_out),
    .error_out    (error_out),
    .mu_a_error_d (mu_a_error_d),
    .err_valid    (err_valid),
    .busy         (busy),
    .count_err    (count_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: wrap sum to 20 bits, saturate y and e, round mu*e by half an LSB and truncate.
  task automatic model(input int n, input logic [15:0] dd, input logic [15:0] mm,
                       output logic [15:0] ny, output logic [15:0] ne, output logic [15:0] nm);
    longint s, y, e, p;
    logic [15:0] t;
    s = 0;
    for (int i = 0; i < n; i++) begin
      t = pb[i];
      s += longint'($signed(t));
    end
    s = s & 64'hFFFFF;
    if (s >= 524288) s -= 1048576;
    y = clamp16(s);
    t = dd;
    e = clamp16(longint'($signed(t)) - y);
    t = mm;
    p = (e * longint'($signed(t)) + 2048) >>> 12;
    ny = 16'(y);
    ne = 16'(e);
    nm = 16'(p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    tap_valid = 1'b0;
    tap_last = 1'b0;
    #1;
    chk("rst_y", 32'(y_out), 32'h0);
    chk("rst_e", 32'(error_out), 32'h0);
    chk("rst_m", 32'(mu_a_error_d), 32'h0);
    chk("rst_vld", 32'(err_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ce", 32'(count_err), 32'h0);
    chk("rst_ov", 32'(overrun), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_y = '0; exp_e = '0; exp_m = '0;
    ce_exp = 1'b0; ov_exp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_vld", 32'(err_valid), 32'h0);
    end
  endtask

  // Stream n products from pb (last on beat n), then check the result pipeline cycle by cycle.
  task automatic send(input int n, input logic [15:0] dd, input logic [15:0] mm,
                      input int gapmax, input bit ovr);
    logic [15:0] ny, ne, nm;
    model(n, dd, mm, ny, ne, nm);
    for (int i = 0; i < n; i++) begin
      for (int g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0; g > 0; g--) begin
        @(negedge clk);
        chk("ce_gap", 32'(count_err), 32'(ce_exp));
        tap_valid = 1'b0;
        tap_last = 1'b0;
      end
      @(negedge clk);
      chk("ce_beat", 32'(count_err), 32'(ce_exp));
      tap_valid = 1'b1;
      tap_in = pb[i];
      tap_last = (i == n - 1);
      if (i == n - 1) begin
        desired = dd;
        mu = mm;
        if (i + 1 != NT) ce_exp = 1'b1;
      end else if (i + 1 > NT) begin
        ce_exp = 1'b1;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tap_valid = ovr;
        tap_in = 16'h7FFF;
        tap_last = 1'b0;
        desired = 16'($urandom);
        mu = 16'($urandom);
      end else begin
        tap_valid = 1'b0;
      end
      case (k)
        0: begin
          chk("vld_t0", 32'(err_valid), 32'h0);
          chk("busy_t0", 32'(busy), 32'h1);
          chk("y_old", 32'(y_out), 32'(exp_y));
          chk("ce_last", 32'(count_err), 32'(ce_exp));
        end
        1: begin
          chk("y", 32'(y_out), 32'(ny));
          chk("e_old", 32'(error_out), 32'(exp_e));
          chk("vld_t1", 32'(err_valid), 32'h0);
          chk("ov", 32'(overrun), 32'(ov_exp));
        end
        2: begin
          chk("e", 32'(error_out), 32'(ne));
          chk("m_old", 32'(mu_a_error_d), 32'(exp_m));
          chk("vld_t2", 32'(err_valid), 32'h0);
          chk("busy_t2", 32'(busy), 32'h1);
        end
        3: begin
          chk("m", 32'(mu_a_error_d), 32'(nm));
          chk("vld_t3", 32'(err_valid), 32'h1);
          chk("busy_t3", 32'(busy), 32'h0);
          chk("y_hold", 32'(y_out), 32'(ny));
        end
        default: begin
          chk("vld_t4", 32'(err_valid), 32'h0);
          chk("m_hold", 32'(mu_a_error_d), 32'(nm));
          chk("ov_end", 32'(overrun), 32'(ov_exp));
        end
      endcase
      if (k == 0 && ovr) ov_exp = 1'b1;
    end
    exp_y = ny; exp_e = ne; exp_m = nm;
  endtask

  task automatic fill(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) pb[i] = v;
  endtask

  initial begin
    reset = 1'b0;
    tap_in = '0; tap_valid = 1'b0; tap_last = 1'b0;
    desired = '0; mu = '0;
    exp_y = '0; exp_e = '0; exp_m = '0;
    ce_exp = 1'b0; ov_exp = 1'b0;
    do_reset();

    // Nominal: y 0x1000, e 0x0800, mu*e 0x0400.
    fill(8, 16'h0200);
    send(8, 16'h1800, 16'h0800, 0, 1'b0);
    chk("t1_y", 32'(exp_y), 32'h1000);
    chk("t1_m", 32'(mu_a_error_d), 32'h0400);

    // Positive overflow saturates y, then e, then a truncated wrap of mu*e.
    fill(8, 16'h7000);
    send(8, 16'h8000, 16'h1000, 0, 1'b0);
    chk("t2_y", 32'(y_out), 32'h7FFF);
    chk("t2_e", 32'(error_out), 32'h8000);
    chk("t2_m", 32'(mu_a_error_d), 32'h8000);

    // Rounding of +/-3 * 0.5.
    fill(8, 16'h0000);
    send(8, 16'h0003, 16'h0800, 1, 1'b0);
    chk("t3_pos", 32'(mu_a_error_d), 32'h0002);
    send(8, 16'hFFFD, 16'h0800, 1, 1'b0);
    chk("t3_neg", 32'(mu_a_error_d), 32'hFFFF);

    // Randomized full-length samples with gaps.
    repeat (20) begin
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(1, 0) == 1) pb[i] = 16'($urandom);
        else pb[i] = 16'(int'($urandom_range(1024, 0)) - 512);
      end
      send(NT, 16'($urandom), 16'($urandom), 2, 1'b0);
    end
    chk("ce_clean", 32'(count_err), 32'h0);

    // Overrun one cycle after tap_last; following sample must be unaffected.
    fill(8, 16'h0200);
    send(8, 16'h1800, 16'h0800, 0, 1'b1);
    chk("t5_ov", 32'(overrun), 32'h1);
    send(8, 16'h1800, 16'h0800, 0, 1'b0);
    chk("t5_y", 32'(y_out), 32'h1000);
    chk("t5_m", 32'(mu_a_error_d), 32'h0400);

    // Short sample (6 products) flags count_err yet completes.
    send(6, 16'h1800, 16'h0800, 0, 1'b0);
    chk("t4_ce", 32'(count_err), 32'h1);
    chk("t4_y", 32'(y_out), 32'h0C00);

    // Long sample: the 9th non-last product sets count_err.
    do_reset();
    fill(10, 16'h0100);
    send(10, 16'h1000, 16'h1000, 0, 1'b0);
    chk("t4b_y", 32'(y_out), 32'h0A00);

    // Reset mid-sample aborts; the next nominal sample is clean.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tap_valid = 1'b1;
      tap_in = 16'h0200;
      tap_last = 1'b0;
    end
    do_reset();
    fill(8, 16'h0200);
    send(8, 16'h1800, 16'h0800, 0, 1'b0);
    chk("t6_y", 32'(y_out), 32'h1000);
    chk("t6_e", 32'(error_out), 32'h0800);
    chk("t6_m", 32'(mu_a_error_d), 32'h0400);
    chk("t6_ce", 32'(count_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
